// File: rtl/mac_window_feeder_if.sv
// Operand/result bundle between the window feeder and its neighbours (loader, MAC, consumer).
// master = feeder side, slave = environment side.
interface mac_window_feeder_if #(
    parameter int IW = 8,
    parameter int OW = 32
);
    logic                 kernel_valid_i;
    logic                 kernel_ready_o;
    logic signed [IW-1:0] kernel_data_i;
    logic signed [OW-1:0] kernel_bias_i;
    logic                 kernel_clear_i;

    logic                 fin_valid_i;
    logic                 fin_ready_o;
    logic signed [IW-1:0] fin_data_i;

    logic                 mac_fin_and_kernel_valid_o;
    logic signed [IW-1:0] mac_fin_data_o;
    logic signed [IW-1:0] mac_kernel_data_o;
    logic signed [OW-1:0] mac_kernel_bias_o;
    logic                 mac_valid_i;
    logic signed [OW-1:0] mac_data_i;
    logic                 mac_ready_o;

    logic                 res_valid_o;
    logic                 res_ready_i;
    logic signed [OW-1:0] res_data_o;
    logic                 timeout_o;

    modport master (
        input  kernel_valid_i, kernel_data_i, kernel_bias_i, kernel_clear_i,
        input  fin_valid_i, fin_data_i,
        input  mac_valid_i, mac_data_i, res_ready_i,
        output kernel_ready_o, fin_ready_o,
        output mac_fin_and_kernel_valid_o, mac_fin_data_o, mac_kernel_data_o, mac_kernel_bias_o,
        output mac_ready_o, res_valid_o, res_data_o, timeout_o
    );

    modport slave (
        output kernel_valid_i, kernel_data_i, kernel_bias_i, kernel_clear_i,
        output fin_valid_i, fin_data_i,
        output mac_valid_i, mac_data_i, res_ready_i,
        input  kernel_ready_o, fin_ready_o,
        input  mac_fin_and_kernel_valid_o, mac_fin_data_o, mac_kernel_data_o, mac_kernel_bias_o,
        input  mac_ready_o, res_valid_o, res_data_o, timeout_o
    );
endinterface

// File: rtl/mac_window_feeder.sv
// Stores a KxK kernel + bias and one activation window, streams them to the MAC as an unbroken
// N-beat burst one cycle after the last activation, then holds the MAC result until res_ready_i.
module mac_window_feeder #(
    parameter int INPUT_BIT_RESOLUTION  = 8,
    parameter int OUTPUT_BIT_RESOLUTION = 32,
    parameter int KERNEL_SIZE           = 3,
    parameter int TIMEOUT_CYCLES        = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mac_window_feeder_if.master bus
);
    localparam int IW = INPUT_BIT_RESOLUTION;
    localparam int OW = OUTPUT_BIT_RESOLUTION;
    localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_KLOAD,
        ST_FILL,
        ST_BURST,
        ST_WAIT,
        ST_OUT
    } state_e;

    state_e               state_q, state_d;
    logic                 run_q, run_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic signed [IW-1:0] w_q   [N];
    logic signed [IW-1:0] w_d   [N];
    logic signed [IW-1:0] act_q [N];
    logic signed [IW-1:0] act_d [N];
    logic signed [OW-1:0] bias_q, bias_d;
    logic signed [OW-1:0] res_q, res_d;
    logic                 timeout_q, timeout_d;

    logic                 k_rdy;
    logic                 idx_last;

    // run_q keeps kernel_ready_o low for the reset cycles themselves.
    assign k_rdy    = run_q && (state_q == ST_KLOAD);
    assign idx_last = (idx_q == AW'(N - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_KLOAD;
            run_q     <= 1'b0;
            idx_q     <= '0;
            tmo_q     <= '0;
            bias_q    <= '0;
            res_q     <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                w_q[i]   <= '0;
                act_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            bias_q    <= bias_d;
            res_q     <= res_d;
            timeout_q <= timeout_d;
            w_q       <= w_d;
            act_q     <= act_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_d     = 1'b1;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        bias_d    = bias_q;
        res_d     = res_q;
        timeout_d = timeout_q;
        w_d       = w_q;
        act_d     = act_q;

        case (state_q)
            ST_KLOAD: begin
                if (k_rdy && bus.kernel_valid_i) begin
                    w_d[idx_q] = bus.kernel_data_i;
                    if (idx_last) begin
                        bias_d  = bus.kernel_bias_i;
                        idx_d   = '0;
                        state_d = ST_FILL;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            ST_FILL: begin
                // A clear wins over a simultaneous first activation; later clears are ignored.
                if (bus.kernel_clear_i && (idx_q == '0)) begin
                    state_d = ST_KLOAD;
                end else if (bus.fin_valid_i) begin
                    act_d[idx_q] = bus.fin_data_i;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = ST_BURST;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            ST_BURST: begin
                if (idx_last) begin
                    idx_d   = '0;
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_WAIT: begin
                if (bus.mac_valid_i) begin
                    res_d   = bus.mac_data_i;
                    state_d = ST_OUT;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FILL;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_OUT: begin
                if (bus.res_ready_i) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_KLOAD;
            end
        endcase
    end

    assign bus.kernel_ready_o             = k_rdy;
    assign bus.fin_ready_o                = (state_q == ST_FILL);
    assign bus.mac_fin_and_kernel_valid_o = (state_q == ST_BURST);
    assign bus.mac_fin_data_o             = act_q[idx_q];
    assign bus.mac_kernel_data_o          = w_q[idx_q];
    assign bus.mac_kernel_bias_o          = bias_q;
    assign bus.mac_ready_o                = (state_q == ST_WAIT);
    assign bus.res_valid_o                = (state_q == ST_OUT);
    assign bus.res_data_o                 = res_q;
    assign bus.timeout_o                  = timeout_q;
endmodule

// File: tb/tb_mac_window_feeder.sv
// Bench for mac_window_feeder: the bench plays loader, MAC and consumer; results are
// predicted from the loaded kernel/window by plain dot-product arithmetic.
`timescale 1ns/1ps
module tb_mac_window_feeder;
    localparam int IW  = 8;
    localparam int OW  = 32;
    localparam int K   = 3;
    localparam int N   = K * K;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mac_window_feeder_if #(.IW(IW), .OW(OW)) bus ();

    mac_window_feeder #(
        .INPUT_BIT_RESOLUTION (IW),
        .OUTPUT_BIT_RESOLUTION(OW),
        .KERNEL_SIZE          (K),
        .TIMEOUT_CYCLES       (TMO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int kr_cnt = 0;
    int rv_cnt = 0;
    int last_res = 0;
    logic exp_timeout = 1'b0;
    logic signed [IW-1:0] m_w   [N];
    logic signed [IW-1:0] m_act [N];
    logic signed [OW-1:0] m_bias;

    always @(negedge clk) begin
        if (bus.kernel_ready_o === 1'b1) kr_cnt++;
        if (bus.res_valid_o === 1'b1) rv_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int model_result();
        int s;
        s = int'(m_bias);
        for (int i = 0; i < N; i++) s += int'(m_w[i]) * int'(m_act[i]);
        return s;
    endfunction

    task automatic idle_inputs();
        bus.kernel_valid_i = 1'b0; bus.kernel_data_i = '0; bus.kernel_bias_i = '0;
        bus.kernel_clear_i = 1'b0; bus.fin_valid_i = 1'b0;  bus.fin_data_i = '0;
        bus.mac_valid_i    = 1'b0; bus.mac_data_i = '0;     bus.res_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_timeout = 1'b0;
    endtask

    task automatic rand_kernel();
        for (int i = 0; i < N; i++) m_w[i] = IW'($urandom);
        m_bias = OW'($urandom_range(0, 200000)) - OW'(100000);
    endtask

    task automatic rand_window();
        for (int i = 0; i < N; i++) m_act[i] = IW'($urandom);
    endtask

    task automatic send_kernel();
        for (int i = 0; i < N; i++) begin
            int t;
            @(negedge clk);
            bus.kernel_valid_i = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            t = 0;
            while (bus.kernel_ready_o !== 1'b1 && t < 50) begin @(negedge clk); t++; end
            checks++;
            if (t >= 50) begin errors++; $display("FAIL kernel_ready wait: got 0 for 50 cycles, want 1"); end
            bus.kernel_valid_i = 1'b1;
            bus.kernel_data_i  = m_w[i];
            bus.kernel_bias_i  = (i == N - 1) ? m_bias : OW'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        bus.kernel_valid_i = 1'b0;
    endtask

    task automatic fill_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            int t;
            @(negedge clk);
            bus.fin_valid_i = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            t = 0;
            while (bus.fin_ready_o !== 1'b1 && t < 50) begin @(negedge clk); t++; end
            checks++;
            if (t >= 50) begin errors++; $display("FAIL fin_ready wait: got 0 for 50 cycles, want 1"); end
            bus.fin_valid_i = 1'b1;
            bus.fin_data_i  = m_act[i];
            @(posedge clk);
        end
    endtask

    // Acts as the MAC: accumulates whatever the feeder presents on each beat.
    task automatic check_burst(output int acc);
        acc = 0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            bus.fin_valid_i = 1'b0;
            checks++;
            if ({bus.mac_fin_and_kernel_valid_o, bus.mac_fin_data_o, bus.mac_kernel_data_o, bus.mac_kernel_bias_o}
                !== {1'b1, m_act[k], m_w[k], m_bias}) begin
                errors++;
                $display("FAIL burst beat %0d: got v=%0b a=%0d w=%0d b=%0d, want v=1 a=%0d w=%0d b=%0d", k,
                         bus.mac_fin_and_kernel_valid_o, bus.mac_fin_data_o, bus.mac_kernel_data_o,
                         bus.mac_kernel_bias_o, m_act[k], m_w[k], m_bias);
            end
            acc += int'(bus.mac_fin_data_o) * int'(bus.mac_kernel_data_o);
            if (k == N - 1) acc += int'(bus.mac_kernel_bias_o);
        end
        @(negedge clk);
        checks++;
        if (bus.mac_fin_and_kernel_valid_o !== 1'b0 || bus.mac_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL burst end: got valid=%0b mac_ready=%0b, want valid=0 mac_ready=1",
                     bus.mac_fin_and_kernel_valid_o, bus.mac_ready_o);
        end
    endtask

    task automatic run_window(input int lo, input int exp_res, input int delay, input int hold);
        int acc;
        fill_range(lo, N - 1);
        check_burst(acc);
        repeat (delay) @(negedge clk);
        bus.mac_valid_i = 1'b1;
        bus.mac_data_i  = acc;
        @(posedge clk);
        @(negedge clk);
        bus.mac_valid_i = 1'b0;
        bus.mac_data_i  = OW'($urandom);
        checks++;
        if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== exp_res) begin
            errors++;
            $display("FAIL result: got valid=%0b data=%0d, want valid=1 data=%0d", bus.res_valid_o, bus.res_data_o, exp_res);
        end
        checks++;
        if (bus.timeout_o !== exp_timeout) begin
            errors++;
            $display("FAIL timeout flag: got %0b, want %0b", bus.timeout_o, exp_timeout);
        end
        for (int h = 0; h < hold; h++) begin
            bus.res_ready_i = 1'b0;
            bus.fin_valid_i = 1'b1;
            bus.fin_data_i  = IW'($urandom);
            bus.mac_valid_i = 1'b1;
            bus.mac_data_i  = OW'($urandom);
            @(negedge clk);
            checks++;
            if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== exp_res || bus.fin_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: got valid=%0b data=%0d fin_ready=%0b, want 1 %0d 0", h,
                         bus.res_valid_o, bus.res_data_o, bus.fin_ready_o, exp_res);
            end
        end
        bus.fin_valid_i = 1'b0;
        bus.mac_valid_i = 1'b0;
        bus.res_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready_i = 1'b0;
        checks++;
        if (bus.fin_ready_o !== 1'b1 || bus.res_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL accept: got fin_ready=%0b res_valid=%0b, want 1 0", bus.fin_ready_o, bus.res_valid_o);
        end
        last_res = exp_res;
    endtask

    task automatic clear_kernel();
        @(negedge clk);
        bus.kernel_clear_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.kernel_clear_i = 1'b0;
        checks++;
        if (bus.kernel_ready_o !== 1'b1 || bus.fin_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL clear at count 0: got kernel_ready=%0b fin_ready=%0b, want 1 0", bus.kernel_ready_o, bus.fin_ready_o);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({bus.kernel_ready_o, bus.fin_ready_o, bus.mac_fin_and_kernel_valid_o, bus.mac_ready_o,
             bus.res_valid_o, bus.timeout_o, bus.mac_fin_data_o, bus.mac_kernel_data_o,
             bus.mac_kernel_bias_o, bus.res_data_o} !== '0) begin
            errors++;
            $display("FAIL %s: outputs not all zero, got kr=%0b fr=%0b v=%0b mr=%0b rv=%0b to=%0b a=%0h w=%0h b=%0h r=%0h, want all 0",
                     name, bus.kernel_ready_o, bus.fin_ready_o, bus.mac_fin_and_kernel_valid_o, bus.mac_ready_o,
                     bus.res_valid_o, bus.timeout_o, bus.mac_fin_data_o, bus.mac_kernel_data_o,
                     bus.mac_kernel_bias_o, bus.res_data_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_all_zero("reset state");
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.kernel_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL kernel_ready after reset: got %0b, want 1", bus.kernel_ready_o);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++) begin m_w[i] = 8'sd1; m_act[i] = IW'(i + 1); end
        m_bias = 32'sd5;
        send_kernel();
        run_window(0, 50, 2, 0);
    endtask

    task automatic test_kernel_reuse();
        int k0;
        k0 = kr_cnt;
        for (int i = 0; i < N; i++) m_act[i] = 8'sd2;
        run_window(0, 23, $urandom_range(0, 5), 1);
        for (int i = 0; i < N; i++) m_act[i] = IW'(N - i);
        run_window(0, 50, $urandom_range(0, 5), 0);
        checks++;
        if (kr_cnt !== k0) begin
            errors++;
            $display("FAIL kernel reuse: kernel_ready seen high %0d cycles, want 0", kr_cnt - k0);
        end
    endtask

    task automatic test_backpressure();
        rand_window();
        run_window(0, model_result(), 1, 5);
    endtask

    task automatic test_kernel_clear();
        clear_kernel();
        rand_kernel();
        send_kernel();
        rand_window();
        fill_range(0, 2);
        @(negedge clk);
        bus.fin_valid_i    = 1'b0;
        bus.kernel_clear_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.kernel_clear_i = 1'b0;
        checks++;
        if (bus.fin_ready_o !== 1'b1 || bus.kernel_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL clear ignored mid-fill: got fin_ready=%0b kernel_ready=%0b, want 1 0", bus.fin_ready_o, bus.kernel_ready_o);
        end
        run_window(3, model_result(), $urandom_range(0, 4), 0);
    endtask

    task automatic test_random();
        repeat (4) begin
            rand_window();
            run_window(0, model_result(), $urandom_range(0, 6), $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back();
        repeat (3) begin
            rand_window();
            run_window(0, model_result(), 0, 0);
        end
    endtask

    task automatic test_timeout();
        int acc, c, rv0;
        rand_window();
        rv0 = rv_cnt;
        fill_range(0, N - 1);
        check_burst(acc);
        c = 0;
        while (bus.timeout_o !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        checks++;
        if (c !== TMO) begin errors++; $display("FAIL timeout latency: got %0d cycles, want %0d", c, TMO); end
        checks++;
        if (bus.fin_ready_o !== 1'b1 || bus.mac_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout state: got fin_ready=%0b mac_ready=%0b, want 1 0", bus.fin_ready_o, bus.mac_ready_o);
        end
        checks++;
        if (bus.res_data_o !== last_res) begin
            errors++;
            $display("FAIL timeout res_data: got %0d, want %0d", bus.res_data_o, last_res);
        end
        checks++;
        if (rv_cnt !== rv0) begin errors++; $display("FAIL timeout res_valid: got %0d valid cycles, want 0", rv_cnt - rv0); end
        exp_timeout = 1'b1;
        rand_window();
        run_window(0, model_result(), 2, 0);
    endtask

    task automatic test_timeout_race();
        do_reset();
        rand_kernel();
        send_kernel();
        rand_window();
        run_window(0, model_result(), TMO - 1, 0);
    endtask

    task automatic test_extreme();
        clear_kernel();
        for (int i = 0; i < N; i++) begin m_w[i] = -8'sd128; m_act[i] = 8'sd127; end
        m_bias = -32'sd4096;
        send_kernel();
        run_window(0, -150400, 3, 0);
    endtask

    task automatic test_reset_mid_burst();
        rand_window();
        fill_range(0, N - 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.fin_valid_i = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset mid-burst");
        rst_n = 1'b1;
        exp_timeout = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.kernel_ready_o !== 1'b1 || bus.fin_ready_o !== 1'b0 || bus.mac_fin_and_kernel_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL after mid-burst reset: got kr=%0b fr=%0b v=%0b, want 1 0 0",
                     bus.kernel_ready_o, bus.fin_ready_o, bus.mac_fin_and_kernel_valid_o);
        end
        rand_kernel();
        send_kernel();
        rand_window();
        run_window(0, model_result(), 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_kernel_reuse();
        test_backpressure();
        test_kernel_clear();
        test_random();
        test_back_to_back();
        test_timeout();
        test_timeout_race();
        test_extreme();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
